// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES step sequencer front-end.
//   seq_state_t : sequencer state encoding (IDLE/LOAD/RUN/DONE)
//   xpose_idx   : maps row-major message byte k to its column-major
//                 state byte position for a block of nb columns
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // Message byte k sits in row (k mod 4), column (k / 4) of the state.
    function automatic int xpose_idx(input int k, input int nb);
        return (k % 32'sd4) * nb + (k / 32'sd4);
    endfunction

endpackage

// File: rtl/aes_tick_gen.sv
// -----------------------------------------------------------------------------
// aes_tick_gen
// Produces the internal step tick for the sequencer.
//   CLOCK_50 : system clock (rising edge)
//   reset    : synchronous, active-high
//   run_mode : 1 = free-running divider, 0 = one tick per step_btn press
//   step_btn : synchronised, debounced button level
//   tick     : one-cycle step pulse (not yet gated by sequencer state)
// -----------------------------------------------------------------------------
module aes_tick_gen #(
    parameter int DIV_COUNT = 8000000,
    parameter int CNT_W     = 23
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic run_mode,
    input  logic step_btn,
    output logic tick
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] DIV_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] div_r;
    logic             btn_q_r;
    logic             mode_q_r;

    // Divider, button history and previous-mode register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_r    <= '0;
            btn_q_r  <= 1'b0;
            // Start aligned with the current mode so reset is not seen as a switch.
            mode_q_r <= run_mode;
        end else begin
            btn_q_r  <= step_btn;
            mode_q_r <= run_mode;
            // A mode change restarts the divider so the first free-run tick
            // lands a full DIV_COUNT cycles after the switch.
            if (!run_mode || (run_mode != mode_q_r)) begin
                div_r <= '0;
            end else if (div_r == DIV_LAST) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_ONE;
            end
        end
    end

    // Tick source selection: divider terminal count or button rising edge.
    always_comb begin
        tick = 1'b0;
        if (run_mode) begin
            tick = (div_r == DIV_LAST);
        end else begin
            tick = step_btn & ~btn_q_r;
        end
    end

endmodule

// File: rtl/aes_step_sequencer.sv
// -----------------------------------------------------------------------------
// aes_step_sequencer
// Front-end between board I/O and the AES control unit: step tick
// generation, row/column transposition and start/done sequencing with a
// tick-based watchdog.
//   CLOCK_50, reset           : clock and synchronous active-high reset
//   run_mode, step_btn        : tick source selection / manual step
//   in_valid, in_ready        : message handshake (ready only in IDLE)
//   msg_in, decrypt           : row-major message and mode, latched on accept
//   core_tick, core_start     : step enable and start request to the core
//   core_decrypt, core_state_in : latched mode and column-major message
//   core_done, core_state_out : core completion and column-major result
//   out_valid, out_ready      : result handshake
//   msg_out, timeout          : row-major result / watchdog abort flag
//   busy                      : sequencer not in IDLE
// -----------------------------------------------------------------------------
module aes_step_sequencer
    import aes_pkg::*;
#(
    parameter int NB            = 4,
    parameter int DIV_COUNT     = 8000000,
    parameter int CNT_W         = 23,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              run_mode,
    input  logic              step_btn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:32*NB-1]  msg_in,
    input  logic              decrypt,
    output logic              core_tick,
    output logic              core_start,
    output logic              core_decrypt,
    output logic [0:32*NB-1]  core_state_in,
    input  logic              core_done,
    input  logic [0:32*NB-1]  core_state_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:32*NB-1]  msg_out,
    output logic              timeout,
    output logic              busy
);

    localparam int                WD_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_TICKS - 1);
    localparam logic [WD_W-1:0]   WD_ONE  = WD_W'(1);

    seq_state_t        state_r;
    logic [WD_W-1:0]   watchdog_r;
    logic              tick_s;
    logic [0:32*NB-1]  state_in_s;
    logic [0:32*NB-1]  result_s;

    aes_tick_gen #(
        .DIV_COUNT (DIV_COUNT),
        .CNT_W     (CNT_W)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .run_mode (run_mode),
        .step_btn (step_btn),
        .tick     (tick_s)
    );

    // The core only sees ticks while it is being loaded or is running.
    assign core_tick = tick_s & ((state_r == LOAD) | (state_r == RUN));

    // Row-major <-> column-major byte shuffles for message in and result out.
    always_comb begin
        state_in_s = '0;
        result_s   = '0;
        for (int k = 0; k < 4 * NB; k++) begin
            state_in_s[8 * xpose_idx(k, NB) +: 8] = msg_in[8 * k +: 8];
            result_s[8 * k +: 8] = core_state_out[8 * xpose_idx(k, NB) +: 8];
        end
    end

    // Sequencer FSM with registered handshake and data outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r       <= IDLE;
            watchdog_r    <= '0;
            in_ready      <= 1'b1;
            core_start    <= 1'b0;
            core_decrypt  <= 1'b0;
            core_state_in <= '0;
            out_valid     <= 1'b0;
            msg_out       <= '0;
            timeout       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        core_state_in <= state_in_s;
                        core_decrypt  <= decrypt;
                        core_start    <= 1'b1;
                        in_ready      <= 1'b0;
                        busy          <= 1'b1;
                        state_r       <= LOAD;
                    end
                end
                LOAD: begin
                    if (core_tick) begin
                        core_start <= 1'b0;
                        watchdog_r <= '0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    // A completion beats a watchdog expiry in the same cycle.
                    if (core_done) begin
                        msg_out   <= result_s;
                        timeout   <= 1'b0;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else if (core_tick) begin
                        if (watchdog_r == WD_LAST) begin
                            msg_out   <= '0;
                            timeout   <= 1'b1;
                            out_valid <= 1'b1;
                            state_r   <= DONE;
                        end else begin
                            watchdog_r <= watchdog_r + WD_ONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_step_sequencer.sv
module tb_aes_step_sequencer;

    localparam int DIV = 4;
    localparam int TMO = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // NB = 4 instance
    logic         reset, run_mode, step_btn, in_valid, in_ready, decrypt;
    logic         core_tick, core_start, core_decrypt, core_done;
    logic         out_valid, out_ready, timeout, busy;
    logic [0:127] msg_in, core_state_in, core_state_out, msg_out;

    // NB = 8 instance (result looped back from the transposed input)
    logic         b_reset, b_run_mode, b_step_btn, b_in_valid, b_in_ready, b_decrypt;
    logic         b_core_tick, b_core_start, b_core_decrypt, b_core_done;
    logic         b_out_valid, b_out_ready, b_timeout, b_busy;
    logic [0:255] b_msg_in, b_core_state_in, b_msg_out;
    wire  [0:255] b_core_state_out = b_core_state_in;

    int total = 0;
    int bad   = 0;

    aes_step_sequencer #(.NB(4), .DIV_COUNT(DIV), .CNT_W(3), .TIMEOUT_TICKS(TMO)) dut (
        .CLOCK_50(clk), .reset(reset), .run_mode(run_mode), .step_btn(step_btn),
        .in_valid(in_valid), .in_ready(in_ready), .msg_in(msg_in), .decrypt(decrypt),
        .core_tick(core_tick), .core_start(core_start), .core_decrypt(core_decrypt),
        .core_state_in(core_state_in), .core_done(core_done), .core_state_out(core_state_out),
        .out_valid(out_valid), .out_ready(out_ready), .msg_out(msg_out),
        .timeout(timeout), .busy(busy)
    );

    aes_step_sequencer #(.NB(8), .DIV_COUNT(DIV), .CNT_W(3), .TIMEOUT_TICKS(TMO)) dut8 (
        .CLOCK_50(clk), .reset(b_reset), .run_mode(b_run_mode), .step_btn(b_step_btn),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .msg_in(b_msg_in), .decrypt(b_decrypt),
        .core_tick(b_core_tick), .core_start(b_core_start), .core_decrypt(b_core_decrypt),
        .core_state_in(b_core_state_in), .core_done(b_core_done), .core_state_out(b_core_state_out),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .msg_out(b_msg_out),
        .timeout(b_timeout), .busy(b_busy)
    );

    // Reference transposition: message byte at row r, column c is 4*c + r;
    // in the state it sits at r*nb + c.
    function automatic logic [0:255] ref_xpose(input logic [0:255] m, input int nb);
        logic [0:255] s;
        s = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                s[8*(r*nb + c) +: 8] = m[8*(4*c + r) +: 8];
        return s;
    endfunction

    function automatic logic [0:255] ref_unxpose(input logic [0:255] s, input int nb);
        logic [0:255] m;
        m = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                m[8*(4*c + r) +: 8] = s[8*(r*nb + c) +: 8];
        return m;
    endfunction

    function automatic logic [0:127] x4(input logic [0:127] m);
        logic [0:255] t;
        t = ref_xpose({m, 128'h0}, 4);
        return t[0:127];
    endfunction

    function automatic logic [0:127] ux4(input logic [0:127] s);
        logic [0:255] t;
        t = ref_unxpose({s, 128'h0}, 4);
        return t[0:127];
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance (bounded) until core_tick is seen at a sampling point.
    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        while (core_tick !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check(tag, core_tick, 1'b1);
    endtask

    initial begin
        logic [0:127] msg, msg3, res, held;
        logic [0:255] m8, e8;
        logic         dec;
        int           first, step_ticks, held_ticks, outcome, nticks, dly, n;
        logic         div_moved;

        reset = 1'b1; run_mode = 1'b1; step_btn = 1'b0; in_valid = 1'b0;
        msg_in = '0; decrypt = 1'b0; core_done = 1'b0; core_state_out = '0; out_ready = 1'b0;
        b_reset = 1'b1; b_run_mode = 1'b1; b_step_btn = 1'b0; b_in_valid = 1'b0;
        b_msg_in = '0; b_decrypt = 1'b0; b_core_done = 1'b0; b_out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_flags", {busy, out_valid, core_start, core_tick, timeout, core_decrypt}, 6'b0);
        check("rst_msg_out", msg_out, '0);
        check("rst_state_in", core_state_in, '0);

        // 1. Free-run accept and divider timing
        msg = "This is a test!!";
        reset = 1'b0; in_valid = 1'b1; msg_in = msg; decrypt = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("s1_start", core_start, 1'b1);
        check("s1_in_ready_low", in_ready, 1'b0);
        check("s1_col0", core_state_in[0:31], 32'h54206173);
        check("s1_col1", core_state_in[32:63], 32'h68692074);
        check("s1_state_in", core_state_in, x4(msg));
        first = -1;
        for (int c = 1; c <= 8 && first < 0; c++) begin
            if (core_tick === 1'b1) first = c;
            else @(negedge clk);
        end
        // Divider is 0 in the release cycle; tick on its 4th cycle.
        check("s1_first_tick", first, DIV - 1);
        check("s1_start_at_tick", core_start, 1'b1);
        @(negedge clk);
        check("s1_in_run", {busy, core_start, out_valid, in_ready, core_tick}, 5'b10000);

        // 2. Round trip
        res = 128'hfa6a5db133bba6abe3e8536d223ac295;
        core_done = 1'b1; core_state_out = res;
        @(negedge clk);
        core_done = 1'b0;
        check("s2_valid", {out_valid, timeout}, 2'b10);
        check("s2_word0", msg_out[0:31], 32'hfa33e322);
        check("s2_msg_out", msg_out, ux4(res));
        @(negedge clk);
        check("s2_hold", {out_valid, msg_out}, {1'b1, ux4(res)});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("s2_back_idle", {in_ready, out_valid, busy}, 3'b100);
        // Divider is at its terminal count here but IDLE gates the tick.
        check("s2_idle_gated", core_tick, 1'b0);

        // 3. Single-step: long hold then two pulses
        msg3 = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_mode = 1'b0; in_valid = 1'b1; msg_in = msg3; decrypt = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("s3_decrypt", {core_decrypt, core_start}, 2'b11);
        step_ticks = 0; held_ticks = 0; div_moved = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step_btn = (i < 10 || i == 11 || i == 13) ? 1'b1 : 1'b0;
            #1;
            if (core_tick === 1'b1) begin
                step_ticks++;
                if (i > 0 && i < 10) held_ticks++;
            end
            if (dut.u_tick_gen.div_r !== 3'd0) div_moved = 1'b1;
            @(negedge clk);
        end
        check("s3_tick_count", step_ticks, 3);
        check("s3_held_ticks", held_ticks, 0);
        check("s3_div_held", div_moved, 1'b0);
        check("s3_still_run", {busy, out_valid, core_start}, 3'b100);

        // 4. Watchdog: third tick in RUN aborts
        step_btn = 1'b1;
        #1;
        check("s4_tick", core_tick, 1'b1);
        @(negedge clk);
        step_btn = 1'b0;
        check("s4_timeout", {out_valid, timeout}, 2'b11);
        check("s4_msg_zero", msg_out, '0);
        // core_done and a new message offered in DONE must both be ignored
        core_done = 1'b1; core_state_out = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = 1'b1; msg_in = ~msg3;
        @(negedge clk);
        core_done = 1'b0;
        check("s4_done_ignored", {out_valid, timeout, msg_out}, {2'b11, 128'h0});
        check("s5_holdoff_state_in", core_state_in, x4(msg3));
        check("s5_holdoff_ready", in_ready, 1'b0);
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("s4_back_idle", {in_ready, busy, out_valid}, 3'b100);

        // 5. Reset mid-RUN
        run_mode = 1'b1; in_valid = 1'b1; msg_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        in_valid = 1'b0;
        wait_tick("s5_load_tick");
        @(negedge clk);
        wait_tick("s5_run_tick");
        @(negedge clk);
        check("s5_pre_reset_run", {busy, out_valid}, 2'b10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("s5_rst_ready", in_ready, 1'b1);
        check("s5_rst_flags", {busy, out_valid, core_start, core_tick, timeout, core_decrypt}, 6'b0);
        check("s5_rst_data", {msg_out, core_state_in}, '0);

        // Randomised transactions against the transaction-level model
        for (int t = 0; t < 10; t++) begin
            msg     = {$urandom(), $urandom(), $urandom(), $urandom()};
            res     = {$urandom(), $urandom(), $urandom(), $urandom()};
            dec     = 1'($urandom_range(0, 1));
            outcome = $urandom_range(0, TMO + 1);   // 0..TMO: done after that many RUN ticks
            nticks  = (outcome <= TMO) ? outcome : TMO;
            n = 0;
            while (in_ready !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("rnd_ready", in_ready, 1'b1);
            in_valid = 1'b1; msg_in = msg; decrypt = dec;
            @(negedge clk);
            in_valid = 1'b0;
            check("rnd_accept", {core_start, core_decrypt, core_state_in}, {1'b1, dec, x4(msg)});
            wait_tick("rnd_load_tick");
            @(negedge clk);
            for (int j = 0; j < nticks; j++) begin
                if (j > 0) @(negedge clk);
                wait_tick("rnd_run_tick");
            end
            if (outcome <= TMO) begin
                core_done = 1'b1; core_state_out = res;
            end
            @(negedge clk);
            core_done = 1'b0;
            if (outcome <= TMO) held = ux4(res);
            else held = '0;
            check("rnd_result", {out_valid, timeout, msg_out}, {1'b1, (outcome > TMO), held});
            dly = $urandom_range(0, 2);
            repeat (dly) @(negedge clk);
            check("rnd_held", {out_valid, msg_out}, {1'b1, held});
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("rnd_release", {in_ready, out_valid}, 2'b10);
        end

        // 6. NB = 8 transposition and inverse
        m8 = '0;
        m8[8:15] = 8'hAB;
        e8 = ref_xpose(m8, 8);
        b_reset = 1'b0; b_in_valid = 1'b1; b_msg_in = m8;
        @(negedge clk);
        b_in_valid = 1'b0;
        check("s6_byte8", b_core_state_in[64:71], 8'hAB);
        check("s6_state_in", b_core_state_in, e8);
        n = 0;
        while (b_core_tick !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("s6_tick", b_core_tick, 1'b1);
        @(negedge clk);
        b_core_done = 1'b1;
        @(negedge clk);
        b_core_done = 1'b0;
        check("s6_valid", {b_out_valid, b_timeout}, 2'b10);
        check("s6_msg_out", b_msg_out, m8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
